// File: rtl/mips_pkg.sv
// Shared definitions for the CPU memory-side blocks.
//   dmemState_t : responder FSM states (2-bit encoding)
//   dmemErr_t   : access error classification
//   WORD_W      : data/address word width
//   classifyAddr: decides whether a byte address is usable for a word access
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmemState_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_MISALIGNED = 2'd1,
        ERR_RANGE      = 2'd2
    } dmemErr_t;

    // addrW is log2 of the memory depth in words; anything above the
    // word index field must be zero for the access to hit the RAM.
    function automatic dmemErr_t classifyAddr(input logic [WORD_W-1:0] addr,
                                              input int addrW);
        if (addr[1:0] != 2'b00) return ERR_MISALIGNED;
        if ((addr >> (addrW + 2)) != '0) return ERR_RANGE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data RAM: single port, synchronous write, asynchronous read.
// Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   addr  : word index
//   wdata : write data
//   rdata : combinational read of mem[addr]
module dmem_ram
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data port responder. Accepts one load/store at a time over
// valid/ready, answers after WAIT_CYCLES wait states and stalls the pipeline
// while an access is outstanding.
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid/we/addr/wdata : request from the M stage
//   req_ready             : high in IDLE (request taken when valid & ready)
//   resp_valid            : one-cycle completion pulse
//   resp_rdata, resp_err  : load data / error flag, qualified by resp_valid
//   stall                 : req_valid & ~resp_valid
//
// state | meaning
// IDLE  | ready for a request; latches it on req_valid
// WAIT  | counting down wait states
// RESP  | response presented for one cycle
module dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmemState_t        state, nextState;
    logic [3:0]        waitCnt;
    logic              latWe, latErr;
    logic [ADDR_W-1:0] latIdx;
    logic [WORD_W-1:0] latWdata;
    logic              curWe, curErr;
    logic [ADDR_W-1:0] curIdx;
    logic [WORD_W-1:0] curWdata;
    logic              accept, enterResp, ramWe;
    logic [WORD_W-1:0] ramRdata, rdataReg;
    logic              errReg;

    assign accept = (state == IDLE) & req_valid;

    // With zero wait states RESP is entered on the accept edge itself, so the
    // RAM must see the live request; otherwise it sees the latched copy.
    always_comb begin
        curWe    = latWe;
        curErr   = latErr;
        curIdx   = latIdx;
        curWdata = latWdata;
        if (state == IDLE) begin
            curWe    = req_we;
            curErr   = (classifyAddr(req_addr, ADDR_W) != ERR_NONE);
            curIdx   = req_addr[ADDR_W+1:2];
            curWdata = req_wdata;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (req_valid) nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (waitCnt == 4'd0) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign enterResp = (nextState == RESP) & (state != RESP);
    // Gating with reset keeps a store from committing on an edge inside reset.
    assign ramWe = enterResp & curWe & ~curErr & ~reset;

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ramWe),
        .addr (curIdx),
        .wdata(curWdata),
        .rdata(ramRdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            waitCnt  <= 4'd0;
            latWe    <= 1'b0;
            latErr   <= 1'b0;
            latIdx   <= '0;
            latWdata <= '0;
            rdataReg <= '0;
            errReg   <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                latWe    <= req_we;
                latErr   <= curErr;
                latIdx   <= req_addr[ADDR_W+1:2];
                latWdata <= req_wdata;
                waitCnt  <= CNT_LOAD;
            end else if ((state == WAIT) && (waitCnt != 4'd0)) begin
                waitCnt <= waitCnt - 4'd1;
            end
            // Response registers hold only during RESP so idle outputs read zero.
            if (enterResp) begin
                rdataReg <= (curWe | curErr) ? '0 : ramRdata;
                errReg   <= curErr;
            end else if (state == RESP) begin
                rdataReg <= '0;
                errReg   <= 1'b0;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdataReg;
    assign resp_err   = errReg;
    assign stall      = req_valid & ~resp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with two wait states
// and one with none, driven one at a time, checked against an array model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;            // 0: two-wait-state DUT, 1: zero-wait-state DUT
    logic        reqValid, reqWe;
    logic [31:0] reqAddr, reqWdata;

    logic        ready2, valid2, err2, stall2;
    logic [31:0] rdata2;
    logic        ready0, valid0, err0, stall0;
    logic [31:0] rdata0;

    logic        rv2, rv0;
    logic        reqReady, respValid, respErr, stall;
    logic [31:0] respRdata;

    int testsRun  = 0;
    int failCount = 0;
    int cyc       = 0;
    int lastResp  = 0;

    logic [31:0] model [0:1][0:63];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rv2 = reqValid & ~sel;
    assign rv0 = reqValid & sel;
    assign reqReady  = sel ? ready0 : ready2;
    assign respValid = sel ? valid0 : valid2;
    assign respErr   = sel ? err0   : err2;
    assign respRdata = sel ? rdata0 : rdata2;
    assign stall     = sel ? stall0 : stall2;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(rv2), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(ready2),
        .resp_valid(valid2), .resp_rdata(rdata2), .resp_err(err2), .stall(stall2));

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(rv0), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(ready0),
        .resp_valid(valid0), .resp_rdata(rdata0), .resp_err(err0), .stall(stall0));

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in the low phase of the clock with the DUT in IDLE. Returns in the
    // low phase of the IDLE cycle following the response.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold);
        int lat;
        int expLat;
        bit got;
        bit expErr;
        logic [31:0] expData;
        expErr  = (addr % 4 != 0) || (addr >= 32'd256);
        expData = (we || expErr) ? 32'd0 : model[sel][addr / 4];
        expLat  = sel ? 1 : 3;
        reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata;
        #1;
        checkBit("accept_ready", reqReady, 1'b1);
        checkBit("accept_stall", stall, 1'b1);
        lat = 0; got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (respValid) got = 1;
            else begin
                checkBit("wait_stall", stall, 1'b1);
                checkBit("wait_ready", reqReady, 1'b0);
            end
        end
        lastResp = cyc;
        checkWord("latency", 32'(lat), 32'(expLat));
        if (got) begin
            checkWord("resp_rdata", respRdata, expData);
            checkBit("resp_err", respErr, expErr);
            checkBit("resp_stall", stall, 1'b0);
            checkBit("resp_ready", reqReady, 1'b0);
        end
        if (we && !expErr) model[sel][addr / 4] = wdata;
        if (!hold) reqValid = 1'b0;
        @(negedge clk);
        checkBit("after_ready", reqReady, 1'b1);
        checkBit("after_valid", respValid, 1'b0);
    endtask

    task automatic randomOps(input int n);
        int r;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      a = 32'(4 * $urandom_range(0, 63));
            else if (r < 85) a = 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
            else             a = 32'($urandom) | 32'h100;
            access(1'($urandom_range(0, 1)), a, 32'($urandom), 0);
        end
    endtask

    task automatic readAll();
        for (int i = 0; i < 64; i++) access(1'b0, 32'(4 * i), 32'd0, 0);
    endtask

    initial begin
        int t1;
        reset = 1'b1; sel = 1'b0; reqValid = 1'b0; reqWe = 1'b0;
        reqAddr = '0; reqWdata = '0;
        repeat (3) @(negedge clk);
        checkBit("rst_ready2", ready2, 1'b1);
        checkBit("rst_valid2", valid2, 1'b0);
        checkWord("rst_rdata2", rdata2, 32'd0);
        checkBit("rst_err2", err2, 1'b0);
        checkBit("rst_ready0", ready0, 1'b1);
        checkBit("rst_valid0", valid0, 1'b0);
        checkBit("rst_stall0", stall0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Fill both RAMs so every later load has a known expectation.
        for (int d = 0; d < 2; d++) begin
            sel = 1'(d);
            for (int i = 0; i < 64; i++) access(1'b1, 32'(4 * i), 32'($urandom), 0);
        end

        sel = 1'b0;
        access(1'b1, 32'h10, 32'hDEADBEEF, 0);
        access(1'b0, 32'h10, 32'd0, 0);
        checkWord("sw_lw_value", model[0][4], 32'hDEADBEEF);
        access(1'b0, 32'h12, 32'd0, 0);
        access(1'b0, 32'h10, 32'd0, 0);
        access(1'b1, 32'h100, 32'hA5A5A5A5, 0);
        readAll();

        // Store aborted by reset while in WAIT.
        reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'h20; reqWdata = 32'h12345678;
        @(negedge clk);
        checkBit("abort_in_wait", reqReady, 1'b0);
        reset = 1'b1;
        #1;
        checkBit("abort_ready", reqReady, 1'b1);
        checkBit("abort_valid", respValid, 1'b0);
        reqValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkBit("abort_no_resp", respValid, 1'b0);
        end
        access(1'b0, 32'h20, 32'd0, 0);
        randomOps(60);

        // Zero wait states, back-to-back with req_valid held across RESP.
        sel = 1'b1;
        access(1'b0, 32'h0, 32'd0, 1);
        t1 = lastResp;
        access(1'b0, 32'h4, 32'd0, 0);
        checkWord("b2b_period", 32'(lastResp - t1), 32'd2);
        randomOps(60);
        readAll();

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkBit("idle_stall", stall, 1'b0);
            checkBit("idle_valid", respValid, 1'b0);
            checkBit("idle_ready", reqReady, 1'b1);
            checkWord("idle_rdata", respRdata, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
